// File: rtl/udar_scan_sched.sv
// udar_scan_sched: sweep scheduler for the ultrasonic radar.
// Moves the servo through the angle range one step at a time and waits for
// the servo to settle at each step. It then triggers the HC-SR04 ranging
// driver, never sooner than the sensor's re-trigger gap allows, and collects
// the range or a timeout. Each result is emitted as an (angle, length) record
// on a valid/ready stream.
module udar_scan_sched #(
    parameter int ANGLE_W     = 8,
    parameter int ANGLE_MIN   = 0,
    parameter int ANGLE_MAX   = 180,
    parameter int ANGLE_STEP  = 2,
    parameter int SETTLE_CYC  = 1000000,
    parameter int GAP_CYC     = 3000000,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic               clk50M,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    output logic [ANGLE_W-1:0] servo_angle,
    output logic               meas_en,
    input  logic               meas_done,
    input  logic [15:0]        meas_len,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [ANGLE_W-1:0] pt_angle,
    output logic [15:0]        pt_len,
    output logic               pt_timeout,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_TRIG   = 3'd2,
        S_WAIT   = 3'd3,
        S_EMIT   = 3'd4,
        S_ADV    = 3'd5
    } state_t;

    // Legality checks use one extra bit so that angle+step cannot wrap.
    localparam int AW = ANGLE_W + 1;
    localparam logic [AW-1:0]      A_MIN   = AW'(ANGLE_MIN);
    localparam logic [AW-1:0]      A_MAX   = AW'(ANGLE_MAX);
    localparam logic [AW-1:0]      A_STEP  = AW'(ANGLE_STEP);
    localparam logic [ANGLE_W-1:0] N_MIN   = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] N_STEP  = ANGLE_W'(ANGLE_STEP);
    localparam logic [31:0]        SET_LIM = 32'(SETTLE_CYC - 1);
    localparam logic [31:0]        GAP_LIM = 32'(GAP_CYC);
    localparam logic [31:0]        TMO_LIM = 32'(TIMEOUT_CYC - 1);

    state_t             state_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               dir_up_q;
    logic               stop_pend_q;
    logic [31:0]        settle_cnt_q;
    logic [31:0]        gap_cnt_q;
    logic [31:0]        tmo_cnt_q;
    logic               meas_en_q;
    logic               pt_valid_q;
    logic [ANGLE_W-1:0] pt_angle_q;
    logic [15:0]        pt_len_q;
    logic               pt_timeout_q;
    logic               busy_q;
    logic               sweep_done_q;

    logic [AW-1:0]      angle_wide_s;
    logic               up_ok_s;
    logic               dn_ok_s;
    logic               at_end_s;
    logic               dir_d;
    logic [ANGLE_W-1:0] angle_d;

    // Whether a step is legal in each direction, and where ADV would move next
    always_comb begin
        angle_wide_s = {1'b0, angle_q};
        up_ok_s      = ((angle_wide_s + A_STEP) <= A_MAX);
        dn_ok_s      = (angle_wide_s >= (A_MIN + A_STEP));
        if (dir_up_q) begin
            at_end_s = ~up_ok_s;
        end else begin
            at_end_s = ~dn_ok_s;
        end
        // At an endpoint the direction flips and the step goes the other way,
        // so the endpoint angle is not measured twice.
        dir_d = dir_up_q ^ at_end_s;
        if (dir_d) begin
            angle_d = angle_q + N_STEP;
        end else begin
            angle_d = angle_q - N_STEP;
        end
    end

    // Sweep FSM with all outputs registered
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            angle_q      <= N_MIN;
            dir_up_q     <= 1'b1;
            stop_pend_q  <= 1'b0;
            settle_cnt_q <= 32'd0;
            gap_cnt_q    <= GAP_LIM;
            tmo_cnt_q    <= 32'd0;
            meas_en_q    <= 1'b0;
            pt_valid_q   <= 1'b0;
            pt_angle_q   <= '0;
            pt_len_q     <= 16'd0;
            pt_timeout_q <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            meas_en_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            // The gap counter runs freely and saturates, so the first trigger
            // after reset is not delayed.
            if (gap_cnt_q < GAP_LIM) begin
                gap_cnt_q <= gap_cnt_q + 32'd1;
            end
            if (stop && (state_q != S_IDLE)) begin
                stop_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start) begin
                        angle_q      <= N_MIN;
                        dir_up_q     <= 1'b1;
                        settle_cnt_q <= 32'd0;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 32'd1;
                    if ((settle_cnt_q >= SET_LIM) && (gap_cnt_q >= GAP_LIM)) begin
                        meas_en_q <= 1'b1;
                        state_q   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    gap_cnt_q <= 32'd0;
                    tmo_cnt_q <= 32'd0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                    // A real answer beats a timeout that lands in the same cycle.
                    if (meas_done) begin
                        pt_len_q     <= meas_len;
                        pt_timeout_q <= 1'b0;
                        pt_angle_q   <= angle_q;
                        pt_valid_q   <= 1'b1;
                        state_q      <= S_EMIT;
                    end else if (tmo_cnt_q >= TMO_LIM) begin
                        pt_len_q     <= 16'hFFFF;
                        pt_timeout_q <= 1'b1;
                        pt_angle_q   <= angle_q;
                        pt_valid_q   <= 1'b1;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (pt_ready) begin
                        pt_valid_q <= 1'b0;
                        state_q    <= S_ADV;
                        // sweep_done must be high during ADV itself, so the
                        // endpoint decision ADV will make is computed here.
                        sweep_done_q <= at_end_s & ~(stop_pend_q | stop);
                    end
                end
                S_ADV: begin
                    if (stop_pend_q) begin
                        stop_pend_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (at_end_s && !cont) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        angle_q      <= angle_d;
                        dir_up_q     <= dir_d;
                        settle_cnt_q <= 32'd0;
                        state_q      <= S_SETTLE;
                    end
                end
                default: begin
                    busy_q     <= 1'b0;
                    pt_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign servo_angle = angle_q;
    assign meas_en     = meas_en_q;
    assign pt_valid    = pt_valid_q;
    assign pt_angle    = pt_angle_q;
    assign pt_len      = pt_len_q;
    assign pt_timeout  = pt_timeout_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_udar_scan_sched.sv
// Directed bench for udar_scan_sched on a small sweep range (0..10 step 4,
// settle 10, gap 30, timeout 50). A ranging model answers meas_en after a
// programmable delay with len = 100 + angle.
module tb_udar_scan_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic        pt_ready = 1'b1;
    logic        meas_done = 1'b0;
    logic [15:0] meas_len = 16'd0;
    logic [7:0]  servo_angle;
    logic        meas_en;
    logic        pt_valid;
    logic [7:0]  pt_angle;
    logic [15:0] pt_len;
    logic        pt_timeout;
    logic        busy;
    logic        sweep_done;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc = 0;
    int cd = 0;
    int model_delay = 5;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] l;
        logic        t;
        int          c;
    } rec_t;

    int   en_q[$];
    int   sd_q[$];
    rec_t rec_q[$];

    udar_scan_sched #(
        .ANGLE_W(8), .ANGLE_MIN(0), .ANGLE_MAX(10), .ANGLE_STEP(4),
        .SETTLE_CYC(10), .GAP_CYC(30), .TIMEOUT_CYC(50)
    ) dut (
        .clk50M(clk), .rst(rst), .start(start), .stop(stop), .cont(cont),
        .servo_angle(servo_angle), .meas_en(meas_en), .meas_done(meas_done),
        .meas_len(meas_len), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_angle(pt_angle), .pt_len(pt_len), .pt_timeout(pt_timeout),
        .busy(busy), .sweep_done(sweep_done)
    );

    // Clock starts late so that reset can be checked before any edge
    initial begin
        #20;
        forever #5 clk = ~clk;
    end

    // Event log sampled on the edge the DUT sees; cyc numbers each cycle
    always @(posedge clk) begin
        if (meas_en) en_q.push_back(cyc);
        if (sweep_done) sd_q.push_back(cyc);
        if (pt_valid && pt_ready) rec_q.push_back('{pt_angle, pt_len, pt_timeout, cyc});
        cyc <= cyc + 1;
    end

    // Ranging model: answers model_delay cycles after the meas_en cycle
    always @(negedge clk) begin
        meas_done <= 1'b0;
        if (cd > 0) begin
            if (cd == 1) begin
                meas_done <= 1'b1;
                meas_len  <= 16'd100 + {8'd0, servo_angle};
            end
            cd <= cd - 1;
        end else if (meas_en) begin
            cd <= model_delay;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int idx, input int a, input int l, input int t);
        if (idx < rec_q.size()) begin
            chk({tag, "_angle"}, {24'd0, rec_q[idx].a}, 32'(a));
            chk({tag, "_len"},   {16'd0, rec_q[idx].l}, 32'(l));
            chk({tag, "_tmo"},   {31'd0, rec_q[idx].t}, 32'(t));
        end else begin
            chk({tag, "_present"}, 32'(rec_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic pulse_start(output int n0);
        @(negedge clk);
        start = 1'b1;
        n0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        while (busy !== 1'b0 && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int max, output int c);
        int k = 0;
        while (pt_valid !== 1'b1 && k < max) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        chk(tag, {31'd0, pt_valid}, 32'd1);
    endtask

    task automatic wait_en(input string tag, input int n, input int max);
        int k = 0;
        while (en_q.size() < n && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, (en_q.size() >= n)}, 32'd1);
    endtask

    task automatic wait_rec(input string tag, input int n, input int max);
        int k = 0;
        while (rec_q.size() < n && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, (rec_q.size() >= n)}, 32'd1);
    endtask

    initial begin
        int n0, eb, rb, sb, vc, bad, mingap;

        // ---- Reset with no clock edge ----
        #2 rst = 1'b1;
        #3;
        chk("rst_angle", {24'd0, servo_angle}, 32'd0);
        chk("rst_flags", {26'd0, meas_en, pt_valid, pt_timeout, busy, sweep_done, 1'b0}, 32'd0);
        chk("rst_pt_angle", {24'd0, pt_angle}, 32'd0);
        chk("rst_pt_len", {16'd0, pt_len}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("idle_no_en", 32'(en_q.size()), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // ---- Single sweep, cont=0 ----
        eb = en_q.size(); rb = rec_q.size(); sb = sd_q.size();
        cont = 1'b0; pt_ready = 1'b1; model_delay = 5;
        pulse_start(n0);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_angle", {24'd0, servo_angle}, 32'd0);
        wait_idle("sweep1_idle", 2000);
        chk("sweep1_en_cnt", 32'(en_q.size() - eb), 32'd3);
        chk("sweep1_rec_cnt", 32'(rec_q.size() - rb), 32'd3);
        if (en_q.size() > eb) chk("sweep1_first_en", 32'(en_q[eb] - n0), 32'd11);
        chk_rec("sweep1_r0", rb, 0, 100, 0);
        chk_rec("sweep1_r1", rb + 1, 4, 104, 0);
        chk_rec("sweep1_r2", rb + 2, 8, 108, 0);
        mingap = 1000000;
        for (int i = eb + 1; i < en_q.size(); i++)
            if (en_q[i] - en_q[i-1] < mingap) mingap = en_q[i] - en_q[i-1];
        chk("sweep1_gap_ok", {31'd0, (mingap >= 30)}, 32'd1);
        chk("sweep1_sd_cnt", 32'(sd_q.size() - sb), 32'd1);
        if (sd_q.size() > sb && rec_q.size() >= rb + 3)
            chk("sweep1_sd_cyc", 32'(sd_q[sb]), 32'(rec_q[rb+2].c + 1));

        // ---- Timeout, late done ignored, then stop ----
        eb = en_q.size(); rb = rec_q.size();
        pt_ready = 1'b0; model_delay = 60;
        pulse_start(n0);
        wait_en("tmo_en", eb + 1, 200);
        wait_valid("tmo_valid", 200, vc);
        if (en_q.size() > eb) chk("tmo_latency", 32'(vc - en_q[eb]), 32'd51);
        repeat (15) @(negedge clk);
        chk("tmo_len_held", {16'd0, pt_len}, 32'h0000FFFF);
        chk("tmo_flag_held", {30'd0, pt_valid, pt_timeout}, 32'd3);
        chk("tmo_angle", {24'd0, pt_angle}, 32'd0);
        stop = 1'b1; pt_ready = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("tmo_idle", 200);
        chk("tmo_rec_cnt", 32'(rec_q.size() - rb), 32'd1);
        chk_rec("tmo_r0", rb, 0, 16'hFFFF, 1);
        repeat (60) @(negedge clk);
        chk("tmo_stop_no_en", 32'(en_q.size() - eb), 32'd1);

        // ---- Backpressure ----
        eb = en_q.size(); rb = rec_q.size();
        pt_ready = 1'b0; model_delay = 5;
        pulse_start(n0);
        wait_valid("bp_valid", 200, vc);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pt_valid !== 1'b1 || pt_angle !== 8'd0 || pt_len !== 16'd100 ||
                pt_timeout !== 1'b0 || servo_angle !== 8'd0 || meas_en !== 1'b0) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_no_en", 32'(en_q.size() - eb), 32'd1);
        pt_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", {31'd0, pt_valid}, 32'd0);
        chk("bp_rec_cnt", 32'(rec_q.size() - rb), 32'd1);
        chk_rec("bp_r0", rb, 0, 100, 0);
        wait_idle("bp_idle", 2000);

        // ---- Ping-pong with stop on the 6th point ----
        eb = en_q.size(); rb = rec_q.size(); sb = sd_q.size();
        cont = 1'b1; pt_ready = 1'b1;
        pulse_start(n0);
        wait_en("pp_en6", eb + 6, 3000);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("pp_idle", 500);
        cont = 1'b0;
        chk("pp_rec_cnt", 32'(rec_q.size() - rb), 32'd6);
        chk_rec("pp_r0", rb,     0, 100, 0);
        chk_rec("pp_r1", rb + 1, 4, 104, 0);
        chk_rec("pp_r2", rb + 2, 8, 108, 0);
        chk_rec("pp_r3", rb + 3, 4, 104, 0);
        chk_rec("pp_r4", rb + 4, 0, 100, 0);
        chk_rec("pp_r5", rb + 5, 4, 104, 0);
        chk("pp_sd_cnt", 32'(sd_q.size() - sb), 32'd2);
        if (sd_q.size() >= sb + 2 && rec_q.size() >= rb + 5) begin
            chk("pp_sd0_cyc", 32'(sd_q[sb]), 32'(rec_q[rb+2].c + 1));
            chk("pp_sd1_cyc", 32'(sd_q[sb+1]), 32'(rec_q[rb+4].c + 1));
        end
        repeat (80) @(negedge clk);
        chk("pp_no_more_en", 32'(en_q.size() - eb), 32'd6);

        // ---- Reset mid-WAIT, then restart ----
        eb = en_q.size(); rb = rec_q.size();
        pulse_start(n0);
        wait_en("rw_en", eb + 1, 200);
        rst = 1'b1;
        #1;
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_angle", {24'd0, servo_angle}, 32'd0);
        chk("rw_len", {16'd0, pt_len}, 32'd0);
        chk("rw_flags", {29'd0, pt_valid, pt_timeout, meas_en}, 32'd0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rw_no_rec", 32'(rec_q.size() - rb), 32'd0);
        eb = en_q.size();
        pulse_start(n0);
        wait_idle("rw_idle", 2000);
        if (en_q.size() > eb) chk("rw_first_en", 32'(en_q[eb] - n0), 32'd11);
        chk("rw_rec_cnt", 32'(rec_q.size() - rb), 32'd3);
        chk_rec("rw_r0", rb,     0, 100, 0);
        chk_rec("rw_r1", rb + 1, 4, 104, 0);
        chk_rec("rw_r2", rb + 2, 8, 108, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/udar_scan_sched.md
# udar_scan_sched

Sweep scheduler for the ultrasonic radar. It steps the servo across a configured angle range and lets each step settle. It then fires the HC-SR04 ranging driver through its one-cycle `en` pulse, respecting the sensor's minimum re-trigger interval, and collects `len`/`done` or a timeout. Each point is emitted as an (angle, length) record on a valid/ready stream toward the host/display path.

## Interface
- ANGLE_W, 8, width of angle values
- ANGLE_MIN, 0, first/lowest sweep angle
- ANGLE_MAX, 180, upper sweep bound (inclusive); ANGLE_MAX-ANGLE_MIN >= ANGLE_STEP >= 1
- ANGLE_STEP, 2, angle increment per point
- SETTLE_CYC, 1000000, servo settle cycles after each move (20 ms @ 50 MHz)
- GAP_CYC, 3000000, minimum cycles between consecutive meas_en pulses (60 ms)
- TIMEOUT_CYC, 2000000, cycles in WAIT before a point is declared timed out
- clk50M  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a sweep from ANGLE_MIN, upward; ignored when busy
- stop  in  1  pulse; finish current point, then idle; ignored when idle
- cont  in  1  level, sampled at each sweep end: 1 = ping-pong forever, 0 = single upward sweep
- servo_angle  out  ANGLE_W  commanded servo angle
- meas_en  out  1  one-cycle trigger to ranging driver `en`
- meas_done  in  1  ranging driver `done` pulse
- meas_len  in  16  ranging driver `len`, valid with meas_done
- pt_valid  out  1  point record valid
- pt_ready  in  1  consumer accepts record
- pt_angle  out  ANGLE_W  angle of record
- pt_len  out  16  measured length; 16'hFFFF on timeout
- pt_timeout  out  1  record is a timeout
- busy  out  1  high in every state except IDLE
- sweep_done  out  1  one-cycle pulse when an endpoint of the range is reached

## Operation
- States: IDLE, SETTLE, TRIG, WAIT, EMIT, ADV. All counters are 32-bit.
- IDLE: on start, set servo_angle=ANGLE_MIN, dir=up, clear stop_pend, clear settle counter, go to SETTLE.
- SETTLE: count up. Leave only when count >= SETTLE_CYC-1 and gap_cnt >= GAP_CYC; then go to TRIG.
- TRIG: meas_en=1 for exactly this cycle; clear gap_cnt and the timeout counter; go to WAIT.
- WAIT:
  - meas_done: register meas_len into pt_len, pt_timeout=0, pt_angle=servo_angle; go to EMIT.
  - Timeout counter reaches TIMEOUT_CYC-1 without done: pt_len=FFFF, pt_timeout=1; go to EMIT.
  - Done and timeout in the same cycle: done wins.
- EMIT: pt_valid=1; pt_angle, pt_len and pt_timeout are held stable until pt_valid&&pt_ready; then go to ADV.
- ADV, in priority order:
  - stop_pend: go to IDLE.
  - dir=up, servo_angle+STEP <= ANGLE_MAX: add STEP, go to SETTLE.
  - dir=down, servo_angle >= ANGLE_MIN+STEP: subtract STEP, go to SETTLE.
  - Otherwise (endpoint): pulse sweep_done. If cont=1, reverse dir, step once in the new direction and go to SETTLE; the endpoint is not repeated. If cont=0, go to IDLE.
- Angle arithmetic is computed one bit wider than ANGLE_W, so no wrap occurs. When the range is not a multiple of STEP, the up sweep stops at the last angle <= ANGLE_MAX.
- gap_cnt runs free, saturates at GAP_CYC and resets to GAP_CYC, so the first trigger after reset is not delayed.
- stop is latched into stop_pend in any busy state; stop_pend clears on entering IDLE. meas_done outside WAIT is ignored.

## Timing
- Reset values: IDLE; servo_angle=ANGLE_MIN; meas_en, pt_valid, pt_timeout, busy and sweep_done = 0; pt_angle=0; pt_len=0; gap_cnt=GAP_CYC. Reset mid-operation aborts immediately, with no record emitted.
- start sampled at cycle N: busy=1 and servo_angle updated at N+1.
- First meas_en fires at N+1+SETTLE_CYC (gap already satisfied).
- meas_done at cycle M: pt_valid=1 at M+1.
- Timeout: pt_valid=1 exactly TIMEOUT_CYC+1 cycles after the meas_en cycle.
- Handshake at cycle K: ADV at K+1; next SETTLE at K+2, with servo_angle updated at K+2. sweep_done is asserted in the ADV cycle.
- Any two meas_en pulses are separated by >= GAP_CYC cycles.

## Test plan
Common setup: ANGLE_MIN=0, ANGLE_MAX=10, ANGLE_STEP=4, SETTLE_CYC=10, GAP_CYC=30, TIMEOUT_CYC=50. The ranging model answers meas_done 5 cycles after meas_en, with len = 100 + angle.
- Reset: assert rst with no clock edge -> all outputs at reset values; after release, no meas_en without start.
- Single sweep, cont=0, pt_ready=1: start -> records (0,100), (4,104), (8,108); meas_en spacing >= 30 cycles; one sweep_done; busy falls; exactly 3 meas_en pulses.
- Timeout: model never answers -> record (0, FFFF, pt_timeout=1) with pt_valid exactly 51 cycles after meas_en; a late meas_done is ignored.
- Backpressure: hold pt_ready=0 for 20 cycles in EMIT -> pt_valid and data stay stable, no meas_en, servo_angle unchanged; accepted on the first ready cycle.
- Ping-pong with stop: cont=1 -> angle sequence 0, 4, 8, 4, 0, 4 with sweep_done after 8 and after 0; stop during WAIT of the 6th point -> that record is still emitted, then IDLE with no further meas_en.
- Reset mid-WAIT, then restart: outputs return to reset values; a subsequent start sweeps normally from angle 0.
